// File: rtl/spi_msg_pkg.sv
// Shared types and constants for the SPI message streamer.
package spi_msg_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_GAP   = 3'd5,
    ST_HOLD  = 3'd6
  } state_e;

  // Address width of a DEPTH-entry buffer (never below 1 bit).
  function automatic int aw_of(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_msg_streamer_if.sv
// Host-side and SPI_Master-side signal bundle of the streamer.
interface spi_msg_if
  import spi_msg_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int AW = aw_of(DEPTH);

  logic              wr_en_i;
  logic [AW-1:0]     wr_addr_i;
  logic [BYTE_W-1:0] wr_data_i;
  logic              wr_err_o;
  logic [AW:0]       len_i;
  logic              start_i;
  logic              repeat_i;
  logic              abort_i;
  logic              busy_o;
  logic              done_o;
  logic              aborted_o;
  logic [AW:0]       byte_cnt_o;
  logic [AW-1:0]     rd_addr_i;
  logic [BYTE_W-1:0] rd_data_o;
  logic [BYTE_W-1:0] tx_byte_o;
  logic              tx_dv_o;
  logic              tx_ready_i;
  logic              rx_dv_i;
  logic [BYTE_W-1:0] rx_byte_i;
  logic              cs_n_o;

  // Streamer view.
  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, len_i, start_i, repeat_i, abort_i,
           rd_addr_i, tx_ready_i, rx_dv_i, rx_byte_i,
    output wr_err_o, busy_o, done_o, aborted_o, byte_cnt_o, rd_data_o,
           tx_byte_o, tx_dv_o, cs_n_o
  );

  // Controller / SPI_Master view.
  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, len_i, start_i, repeat_i, abort_i,
           rd_addr_i, tx_ready_i, rx_dv_i, rx_byte_i,
    input  wr_err_o, busy_o, done_o, aborted_o, byte_cnt_o, rd_data_o,
           tx_byte_o, tx_dv_o, cs_n_o
  );
endinterface

// File: rtl/spi_msg_ram.sv
// DEPTH x 8 simple dual-port RAM with a registered, enabled read port.
module spi_msg_ram
  import spi_msg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = aw_of(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [BYTE_W-1:0] rdata_q, rdata_d;

  // Read data only moves when a read is enabled, so it holds between fetches.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem[raddr_i];
  end

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read register; a same-cycle write to the read address returns old data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/spi_msg_streamer.sv
// Streams a buffered message into SPI_Master's byte handshake with CS framing,
// inter-byte gap, repeat and abort, capturing MISO bytes into a read buffer.
module spi_msg_streamer
  import spi_msg_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic   clk_i,
  input  logic   reset_i,
  spi_msg_if.slave bus
);
  localparam int AW = aw_of(DEPTH);
  localparam int CW = 16;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d, byte_cnt_q, byte_cnt_d;
  logic cs_n_q, cs_n_d, busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic wr_err_q, wr_err_d, abort_pend_q, abort_pend_d, rearm_q, rearm_d;
  logic abort_any, fire, last_byte, msg_we, msg_re, cap_we;
  logic [BYTE_W-1:0] msg_rdata;

  assign abort_any = abort_pend_q | (bus.abort_i & busy_q);
  assign fire      = (state_q == ST_SEND) & bus.tx_ready_i;
  assign last_byte = ({1'b0, idx_q} + (AW+1)'(1)) >= len_q;
  assign msg_we    = bus.wr_en_i & ~busy_q;
  assign msg_re    = (state_q == ST_FETCH);
  assign cap_we    = (state_q == ST_WAIT) & bus.rx_dv_i;

  spi_msg_ram #(.DEPTH(DEPTH), .AW(AW)) u_msg (
    .clk_i(clk_i), .reset_i(reset_i),
    .we_i(msg_we), .waddr_i(bus.wr_addr_i), .wdata_i(bus.wr_data_i),
    .re_i(msg_re), .raddr_i(idx_q), .rdata_o(msg_rdata)
  );

  spi_msg_ram #(.DEPTH(DEPTH), .AW(AW)) u_cap (
    .clk_i(clk_i), .reset_i(reset_i),
    .we_i(cap_we), .waddr_i(idx_q), .wdata_i(bus.rx_byte_i),
    .re_i(1'b1), .raddr_i(bus.rd_addr_i), .rdata_o(bus.rd_data_o)
  );

  // Frame sequencer: next-state and output-register computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    cs_n_d       = cs_n_q;
    busy_d       = busy_q;
    rearm_d      = rearm_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    wr_err_d     = bus.wr_en_i & busy_q;
    abort_pend_d = abort_any;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i != '0) begin
            state_d      = ST_SETUP;
            cs_n_d       = 1'b0;
            busy_d       = 1'b1;
            len_d        = (bus.len_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len_i;
            idx_d        = '0;
            byte_cnt_d   = '0;
            cnt_d        = '0;
            rearm_d      = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (abort_any) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          rearm_d = 1'b0;
        end else if (rearm_q) begin
          // One-cycle CS high between repeated frames ends here.
          cs_n_d  = 1'b0;
          rearm_d = 1'b0;
        end else if (cnt_q == CW'(CS_SETUP - 1)) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FETCH: begin
        state_d = abort_any ? ST_HOLD : ST_SEND;
        cnt_d   = '0;
      end
      ST_SEND: begin
        if (fire) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.rx_dv_i) begin
          byte_cnt_d = byte_cnt_q + (AW+1)'(1);
          cnt_d      = '0;
          if (last_byte || abort_any) begin
            state_d = ST_HOLD;
          end else if (GAP_CYCLES == 0) begin
            state_d = ST_FETCH;
            idx_d   = idx_q + AW'(1);
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (abort_any) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = ST_FETCH;
          idx_d   = idx_q + AW'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          cnt_d  = '0;
          cs_n_d = 1'b1;
          if (bus.repeat_i && !abort_any) begin
            state_d    = ST_SETUP;
            rearm_d    = 1'b1;
            idx_d      = '0;
            byte_cnt_d = '0;
          end else begin
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            aborted_d    = abort_any;
            abort_pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      wr_err_q     <= 1'b0;
      abort_pend_q <= 1'b0;
      rearm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      wr_err_q     <= wr_err_d;
      abort_pend_q <= abort_pend_d;
      rearm_q      <= rearm_d;
    end
  end

  // tx_dv_o is qualified by tx_ready_i in the same cycle so it never fires into a busy master.
  assign bus.tx_dv_o    = fire;
  assign bus.tx_byte_o  = msg_rdata;
  assign bus.cs_n_o     = cs_n_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.aborted_o  = aborted_q;
  assign bus.wr_err_o   = wr_err_q;
  assign bus.byte_cnt_o = byte_cnt_q;
endmodule

// File: tb/tb_spi_msg_streamer.sv
// Directed bench for spi_msg_streamer with a behavioural SPI_Master byte model.
module tb_spi_msg_streamer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_msg_if #(.DEPTH(DEPTH)) bus();

  spi_msg_streamer #(.DEPTH(DEPTH), .GAP_CYCLES(4), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] msg [DEPTH];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // SPI_Master stand-in: 32-cycle byte, MISO = MOSI ^ rx_xor.
  int spi_cnt;
  logic [7:0] spi_sh;
  logic [7:0] rx_xor = 8'h00;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_cnt <= 0; spi_sh <= '0;
      bus.tx_ready_i <= 1'b1; bus.rx_dv_i <= 1'b0; bus.rx_byte_i <= '0;
    end else begin
      bus.rx_dv_i <= 1'b0;
      if (spi_cnt == 0) begin
        if (bus.tx_dv_o && bus.tx_ready_i) begin
          spi_sh <= bus.tx_byte_o ^ rx_xor; spi_cnt <= 32; bus.tx_ready_i <= 1'b0;
        end
      end else begin
        spi_cnt <= spi_cnt - 1;
        if (spi_cnt == 1) begin
          bus.rx_dv_i <= 1'b1; bus.rx_byte_i <= spi_sh; bus.tx_ready_i <= 1'b1;
        end
      end
    end
  end

  // Monitor. Events are tagged with the index of the edge that starts the cycle
  // they are visible in; rx_dv_i is tagged with the edge that samples it.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [7:0] tx_log[$];
  int tx_edge[$], rx_edge[$];
  int done_cnt, cs_rise_cnt, cs_fall_cnt, cs_rise_edge, cs_fall_edge, hi_len;
  int ready_viol;
  bit last_aborted, prev_cs = 1'b1;

  always @(negedge clk) begin
    if (bus.tx_dv_o) begin tx_log.push_back(bus.tx_byte_o); tx_edge.push_back(edge_cnt); end
    if (bus.tx_dv_o && !bus.tx_ready_i) ready_viol++;
    if (bus.rx_dv_i) rx_edge.push_back(edge_cnt + 1);
    if (!prev_cs && bus.cs_n_o) begin cs_rise_cnt++; cs_rise_edge = edge_cnt; end
    if (prev_cs && !bus.cs_n_o) begin
      if (cs_rise_cnt > 0) hi_len = edge_cnt - cs_rise_edge;
      cs_fall_cnt++; cs_fall_edge = edge_cnt;
    end
    prev_cs = bus.cs_n_o;
    if (bus.done_o) begin done_cnt++; last_aborted = bus.aborted_o; end
  end

  task automatic clear_logs();
    tx_log.delete(); tx_edge.delete(); rx_edge.delete();
    done_cnt = 0; cs_rise_cnt = 0; cs_fall_cnt = 0; hi_len = 0; ready_viol = 0; last_aborted = 0;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = AW'(a); bus.wr_data_i = d;
    @(posedge clk); #1;
    bus.wr_en_i = 1'b0;
  endtask

  task automatic rd_cap(input int a, output logic [7:0] d);
    bus.rd_addr_i = AW'(a);
    @(posedge clk); #1;
    d = bus.rd_data_o;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (done_cnt == 0 && t < 5000) begin @(posedge clk); #1; t++; end
    chk({nm, "_done_seen"}, int'(done_cnt > 0), 1);
  endtask

  typedef struct {
    int         len;
    bit         rpt;
    int         abort_idx;   // abort once this byte index is in flight; -1 = none
    bit         ab_st;       // abort_i together with start_i
    logic [7:0] xr;          // MISO corruption mask for capture checks
    int         exp_tx;
    int         exp_cnt;
    bit         exp_ab;
    int         exp_rises;
  } vec_t;

  task automatic run_vec(input int vi, input vec_t v);
    int lc, t;
    bit ab_sent;
    logic [7:0] d;
    string p;
    p = $sformatf("v%0d", vi);
    clear_logs();
    rx_xor = v.xr;
    lc = (v.len > DEPTH) ? DEPTH : v.len;
    bus.len_i = (AW+1)'(v.len); bus.repeat_i = v.rpt; bus.abort_i = v.ab_st; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    ab_sent = 0; t = 0;
    while (done_cnt == 0 && t < 5000) begin
      if (v.rpt && tx_log.size() > lc) bus.repeat_i = 1'b0;
      if (v.abort_idx >= 0 && !ab_sent && tx_log.size() == v.abort_idx + 1) begin
        bus.abort_i = 1'b1; ab_sent = 1;
      end
      @(posedge clk); #1;
      bus.abort_i = 1'b0; t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({p, "_done_cnt"}, done_cnt, 1);
    chk({p, "_aborted"}, int'(last_aborted), int'(v.exp_ab));
    chk({p, "_tx_count"}, tx_log.size(), v.exp_tx);
    for (int i = 0; i < tx_log.size() && i < v.exp_tx; i++)
      chk($sformatf("%s_tx_byte%0d", p, i), int'(tx_log[i]), int'(msg[i % lc]));
    chk({p, "_byte_cnt"}, int'(bus.byte_cnt_o), v.exp_cnt);
    chk({p, "_cs_rises"}, cs_rise_cnt, v.exp_rises);
    chk({p, "_cs_idle"}, int'(bus.cs_n_o), 1);
    chk({p, "_busy_idle"}, int'(bus.busy_o), 0);
    chk({p, "_ready_viol"}, ready_viol, 0);
    if (v.rpt) chk({p, "_cs_high_between"}, hi_len, 1);
    for (int i = 0; i < v.exp_cnt && i < lc; i++) begin
      rd_cap(i, d);
      chk($sformatf("%s_cap%0d", p, i), int'(d), int'(msg[i] ^ v.xr));
    end
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0] init [DEPTH] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F,
                                 8'h72, 8'h6C, 8'h64, 8'h21, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    int t;
    msg = init;
    //         len rpt abort st  xor    tx  cnt ab rises
    vecs[0] = '{12, 1'b0, -1, 1'b0, 8'h00, 12, 12, 1'b0, 1};
    vecs[1] = '{31, 1'b0, -1, 1'b0, 8'h5A, 16, 16, 1'b0, 1};
    vecs[2] = '{ 3, 1'b1, -1, 1'b0, 8'hC3,  6,  3, 1'b0, 2};
    vecs[3] = '{12, 1'b0,  5, 1'b0, 8'h0F,  6,  6, 1'b1, 1};
    vecs[4] = '{ 1, 1'b0, -1, 1'b1, 8'h81,  1,  1, 1'b0, 1};

    bus.wr_en_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.len_i = '0;
    bus.start_i = 0; bus.repeat_i = 0; bus.abort_i = 0; bus.rd_addr_i = '0;

    // Reset state
    #12;
    chk("rst_cs_n", int'(bus.cs_n_o), 1);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_aborted", int'(bus.aborted_o), 0);
    chk("rst_tx_dv", int'(bus.tx_dv_o), 0);
    chk("rst_wr_err", int'(bus.wr_err_o), 0);
    chk("rst_tx_byte", int'(bus.tx_byte_o), 0);
    chk("rst_byte_cnt", int'(bus.byte_cnt_o), 0);
    chk("rst_rd_data", int'(bus.rd_data_o), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) wr(i, msg[i]);

    for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

    // Framing timing with CS_SETUP=2, GAP_CYCLES=4, CS_HOLD=2
    run_vec(5, '{2, 1'b0, -1, 1'b0, 8'h00, 2, 2, 1'b0, 1});
    if (tx_edge.size() == 2 && rx_edge.size() == 2) begin
      chk("t_csfall_to_dv", tx_edge[0] - cs_fall_edge, 3);
      chk("t_rxdv_to_dv", tx_edge[1] - rx_edge[0], 5);
      chk("t_rxdv_to_csrise", cs_rise_edge - rx_edge[1], 2);
    end else begin
      chk("t_event_counts", tx_edge.size() * 10 + rx_edge.size(), 22);
    end

    // Zero-length start
    clear_logs();
    bus.len_i = '0; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    chk("len0_done", int'(bus.done_o), 1);
    chk("len0_busy", int'(bus.busy_o), 0);
    @(posedge clk); #1;
    chk("len0_done_pulse", int'(bus.done_o), 0);
    chk("len0_cs_quiet", cs_fall_cnt, 0);

    // Write while busy is dropped and flagged
    clear_logs();
    bus.len_i = 5'd4; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr(0, 8'hEE);
    chk("wrerr_pulse", int'(bus.wr_err_o), 1);
    @(posedge clk); #1;
    chk("wrerr_clear", int'(bus.wr_err_o), 0);
    wait_done("wrerr");
    run_vec(6, '{1, 1'b0, -1, 1'b0, 8'h33, 1, 1, 1'b0, 1});

    // Reset in the middle of a byte
    clear_logs();
    bus.len_i = 5'd4; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    t = 0;
    while (tx_log.size() == 0 && t < 200) begin @(posedge clk); #1; t++; end
    chk("rstmid_first_dv", tx_log.size(), 1);
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    chk("rstmid_cs_n", int'(bus.cs_n_o), 1);
    chk("rstmid_tx_dv", int'(bus.tx_dv_o), 0);
    chk("rstmid_busy", int'(bus.busy_o), 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("rstmid_no_done", done_cnt, 0);
    chk("rstmid_one_dv", tx_log.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
